// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring
// divide on magnitudes, then a one-cycle sign/special-case fix-up and a done pulse.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            we_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [5:0]      LAST    = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONE = '1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  state_t              state;
  logic [5:0]          cnt;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     a_raw;
  logic [XLEN-1:0]     m;
  logic [2*XLEN-1:0]   acc;
  logic                b_zero;
  logic                ovf;
  logic                neg_res;
  logic                neg_rem;

  logic                is_div_in;
  logic                sa_in;
  logic                sb_in;
  logic                neg_a_in;
  logic                neg_b_in;
  logic [XLEN-1:0]     a_mag_in;
  logic [XLEN-1:0]     b_mag_in;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   div_next;

  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     fix_res;

  // Operand signedness: MUL/MULH signed x signed, MULHSU signed x unsigned,
  // MULHU unsigned; DIV/REM signed, DIVU/REMU unsigned.
  always_comb begin
    is_div_in = funct3[2];
    sa_in     = is_div_in ? ~funct3[0] : (funct3 != 3'b011);
    sb_in     = is_div_in ? ~funct3[0] : ~funct3[1];
    neg_a_in  = sa_in & rs1_data[XLEN-1];
    neg_b_in  = sb_in & rs2_data[XLEN-1];
    a_mag_in  = cond_neg(rs1_data, neg_a_in);
    b_mag_in  = cond_neg(rs2_data, neg_b_in);
  end

  // One iteration step: acc = {hi, lo}; multiply keeps the multiplier in lo and
  // shifts the partial product in from the top, divide shifts the quotient in at bit 0.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = rem_sh - {1'b0, m};
    div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod    = cond_neg_wide(acc, neg_res);
    quo     = cond_neg(acc[XLEN-1:0], neg_res);
    rem     = cond_neg(acc[2*XLEN-1:XLEN], neg_rem);
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = b_zero ? ALL_ONE : (ovf ? MIN_NEG : quo);
      default:                fix_res = b_zero ? a_raw : (ovf ? '0 : rem);
    endcase
  end

  // Datapath registers carry no reset; they are always reloaded on acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_q    <= funct3;
      rd_q    <= rd_in;
      a_raw   <= rs1_data;
      b_zero  <= (rs2_data == '0);
      ovf     <= funct3[2] & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == ALL_ONE);
      neg_res <= neg_a_in ^ neg_b_in;
      neg_rem <= neg_a_in;
      if (funct3[2]) begin
        acc <= {{XLEN{1'b0}}, a_mag_in};
        m   <= b_mag_in;
      end else begin
        acc <= {{XLEN{1'b0}}, b_mag_in};
        m   <= a_mag_in;
      end
    end else if (state == CALC) begin
      acc <= op_q[2] ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      we_out <= 1'b0;
      rd_out <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done   <= 1'b0;
          we_out <= 1'b0;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          rd_out <= rd_q;
          done   <= 1'b1;
          we_out <= (rd_q != 5'd0);
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done   <= 1'b0;
          we_out <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes hand-computed expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        we_out;
  logic [4:0]  rd_out;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .we_out(we_out), .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // done is sampled on the falling edge just before edge T+34.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1 with result %h expected no done", result);
      end else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        check("we_out", {31'd0, we_out}, {31'd0, e.we});
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit push);
    int g = 0;
    @(negedge clk);
    while ((busy || done) && g < 100) begin
      @(negedge clk);
      g++;
    end
    busy_cnt = 0;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (push) q.push_back('{exp, rd, (rd != 5'd0), cyc + 33});
    start    = 1'b0;
    funct3   = ~f3;
    rs1_data = ~a;
    rs2_data = a ^ b ^ 32'h5A5A_A5A5;
    rd_in    = ~rd;
  endtask

  task automatic wait_done();
    int g = 0;
    while (q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp);
    start_op(f3, a, b, rd, exp, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;

    // MUL with busy width
    run(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    check("busy_cycles", 32'(busy_cnt), 32'd33);

    run(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    run(3'b001, 32'hFFFF_FFFF, 32'd1,         5'd4, 32'hFFFF_FFFF);
    run(3'b011, 32'hFFFF_FFFF, 32'd1,         5'd4, 32'h0000_0000);

    run(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF);
    run(3'b101, 32'd100, 32'd7, 5'd8, 32'd14);
    run(3'b111, 32'd100, 32'd7, 5'd9, 32'd2);

    // divide-by-zero and signed overflow
    run(3'b101, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
    run(3'b111, 32'd5, 32'd0, 5'd11, 32'd5);
    run(3'b100, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF);
    run(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFF9);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);

    run(3'b000, 32'd3, 32'd4, 5'd0, 32'd12);

    // second start mid-CALC must be ignored
    done_cnt = 0;
    start_op(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd3; rd_in = 5'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (40) @(posedge clk);
    #1;
    check("single_done", 32'(done_cnt), 32'd1);

    // reset mid-CALC aborts the op
    start_op(3'b000, 32'd9, 32'd9, 5'd20, 32'd81, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);

    run(3'b000, 32'd7, 32'd3, 5'd31, 32'd21);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
